weight_row_mac: RTL
===================

Name: weight_row_mac

Overview:
Downstream consumer of a 28-entry x 16-bit weight BRAM (one BRAM per neuron row segment, e.g. weight_0_20_2).
- Sequences the BRAM read port and streams in 28 signed Q8.8 activations.
- Multiply-accumulates activation x weight and returns one saturated Q8.8 partial sum per row through a valid/ready handshake.
- Sits between the input-pixel buffer and the neuron summation/activation stage.

Parameters:
N_ELEM, 28, number of weight/activation pairs per row (BRAM depth)
ADDR_W, 5, BRAM address width (ceil(log2(N_ELEM)))
DATA_W, 16, activation, weight and result width (signed two's complement)
FRAC_BITS, 8, fractional bits of the Q format (Q8.8)
ACC_W, 37, accumulator width (2*DATA_W + ADDR_W; no internal overflow for N_ELEM <= 32)

Ports:
CLK  in  1  system clock; all state updates on posedge; BRAM samples on negedge
RST  in  1  synchronous active-high reset
START  in  1  single-cycle pulse: begin a row; honoured only in IDLE
BUSY  out  1  high in any state other than IDLE
PIX_DATA  in  DATA_W  signed Q8.8 activation
PIX_VALID  in  1  activation valid
PIX_READY  out  1  block accepts activation
W_ADDR  out  ADDR_W  BRAM address
W_EN  out  1  BRAM enable
W_WE  out  1  BRAM write enable, tied 0
W_DI  out  DATA_W  BRAM write data, tied 0
W_DO  in  DATA_W  BRAM read data, signed Q8.8
OUT_DATA  out  DATA_W  saturated Q8.8 row sum
OUT_VALID  out  1  result valid, held until taken
OUT_READY  in  1  consumer accepts result

Behaviour:
- Reset: state IDLE, element counter 0, accumulator 0, pipeline valid bits 0. Output reset values: OUT_VALID=0, OUT_DATA=0, BUSY=0, PIX_READY=0, W_EN=0, W_ADDR=0. Reset mid-row aborts the row, discards partial sum, emits no result. BRAM contents are untouched.
- States and transitions:
  - IDLE -> RUN on START. The accumulator is cleared on that same edge.
  - RUN -> DRAIN on the edge accepting beat N_ELEM-1.
  - DRAIN -> DONE when both pipeline valid bits are 0.
  - DONE -> IDLE on the edge where OUT_VALID & OUT_READY.
- START outside IDLE is ignored. No queuing.
- PIX_READY = (state==RUN). A beat is accepted on a posedge with PIX_VALID & PIX_READY.
- Read issue is combinational from the same handshake: W_EN = PIX_VALID & PIX_READY, W_ADDR = element counter. The counter increments per accepted beat (0..N_ELEM-1, no wrap) and clears on entering RUN.
- BRAM returns W_DO at the following negedge. Stage 1 samples it at the next posedge: product = activation_reg x W_DO, full 2*DATA_W signed, registered with valid bit.
- Stage 2: accumulator += sign-extended product, registered with valid bit.
- PIX_VALID gaps insert bubbles. Result is independent of gap pattern. W_EN pulses exactly N_ELEM times per row.
- Result: acc >>> FRAC_BITS (arithmetic, truncation toward -inf), then saturated to [0x8000, 0x7FFF]. Registered into OUT_DATA on the DONE entry edge.
- OUT_VALID rises with DONE. OUT_DATA is stable while OUT_VALID & !OUT_READY. OUT_VALID clears on handshake.
- Latency:
  - Last beat accepted at edge t gives OUT_VALID high after edge t+3.
  - With START at edge s and continuous PIX_VALID, beats are accepted at s+1..s+28 and OUT_VALID is high after edge s+31.
- Simultaneous events: RST has priority over everything. START during DONE, even coincident with OUT_READY, is ignored. The next row needs START in IDLE.

Decomposition:
- Shared package ann_pkg:
  - constants DATA_W, FRAC_BITS, N_ELEM, ADDR_W, ACC_W;
  - state encoding {IDLE, RUN, DRAIN, DONE};
  - function sat_q88(acc) performing the shift and saturation.
- One sub-module, q88_mac_stage: product register, accumulator, valid pipeline, clear input. The FSM, counter and BRAM/handshake logic stay in weight_row_mac.

Test Plan:
- All weights 0x0100, all activations 0x0100, continuous valid -> OUT_DATA=0x1C00 (28.0), OUT_VALID high after edge s+31.
- Weights 0x7FFF, activations 0x7FFF -> OUT_DATA=0x7FFF. Weights 0x7FFF, activations 0x8000 -> 0x8000. Weight[k]=0x0100*(k+1), activations alternating 0x0100/0xFF00 -> 0xF200 (-14.0).
- Same data as case 1 with PIX_VALID randomly low ~50% -> OUT_DATA=0x1C00. Exactly 28 W_EN pulses, W_ADDR 0..27 in order.
- OUT_READY low 5 cycles after OUT_VALID -> OUT_DATA/OUT_VALID unchanged, PIX_READY=0, START pulses ignored. Then OUT_READY=1 -> IDLE next cycle.
- RST asserted after 10 beats -> next cycle BUSY=0, OUT_VALID=0, PIX_READY=0. New START with case 1 data -> 0x1C00, no residue from the aborted row.
- START pulsed mid-RUN -> counter and accumulator unaffected, result equals undisturbed run.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared constants, FSM encoding and Q8.8 result formatting for the row MAC.
package ann_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAC_BITS = 8;
   localparam int N_ELEM    = 28;
   localparam int ADDR_W    = 5;
   localparam int ACC_W     = 2 * DATA_W + ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   // Drop the extra fraction bits (arithmetic shift, rounds toward -inf) and
   // clamp to the Q8.8 range. The value fits when every bit from the Q8.8
   // sign bit upward is a copy of the sign.
   function automatic logic [DATA_W-1:0] sat_q88(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] shifted;
      logic [ACC_W-DATA_W:0]   top_bits;
      shifted  = acc >>> FRAC_BITS;
      top_bits = shifted[ACC_W-1:DATA_W-1];
      if ((&top_bits) || !(|top_bits)) begin
         sat_q88 = shifted[DATA_W-1:0];
      end else if (shifted[ACC_W-1]) begin
         sat_q88 = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sat_q88 = {1'b0, {(DATA_W-1){1'b1}}};
      end
   endfunction

endpackage

// File: rtl/weight_row_mac_q88_mac_stage.sv
// Multiply-accumulate datapath: activation register, product register and
// accumulator, each gated by its own valid bit so input gaps become bubbles.
module q88_mac_stage
   import ann_pkg::*;
(
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     clear,
   input  logic                     beat,
   input  logic [DATA_W-1:0]        act,
   input  logic [DATA_W-1:0]        w,
   output logic signed [ACC_W-1:0]  acc,
   output logic                     pending
);

   logic signed [DATA_W-1:0]   act_reg;
   logic                       act_valid_reg;
   logic signed [2*DATA_W-1:0] prod_reg;
   logic                       prod_valid_reg;
   logic signed [ACC_W-1:0]    acc_reg;

   // Activation is captured on acceptance; the matching weight arrives from
   // the BRAM one cycle later, so the multiply happens on the following edge.
   always_ff @(posedge clk) begin
      if (srst) begin
         act_reg        <= '0;
         act_valid_reg  <= 1'b0;
         prod_reg       <= '0;
         prod_valid_reg <= 1'b0;
         acc_reg        <= '0;
      end else begin
         act_valid_reg  <= beat;
         prod_valid_reg <= act_valid_reg;
         if (beat) begin
            act_reg <= $signed(act);
         end
         if (act_valid_reg) begin
            prod_reg <= act_reg * $signed(w);
         end
         if (clear) begin
            acc_reg <= '0;
         end else if (prod_valid_reg) begin
            acc_reg <= acc_reg + {{(ACC_W-2*DATA_W){prod_reg[2*DATA_W-1]}}, prod_reg};
         end
      end
   end

   assign acc     = acc_reg;
   assign pending = act_valid_reg | prod_valid_reg;

endmodule

// File: rtl/weight_row_mac.sv
// Row sequencer: walks the weight BRAM in step with accepted activations,
// feeds the MAC datapath and hands back one saturated Q8.8 sum per row.
module weight_row_mac
   import ann_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   output logic              BUSY,
   input  logic [DATA_W-1:0] PIX_DATA,
   input  logic              PIX_VALID,
   output logic              PIX_READY,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic              W_EN,
   output logic              W_WE,
   output logic [DATA_W-1:0] W_DI,
   input  logic [DATA_W-1:0] W_DO,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY
);

   state_t                   state_reg;
   state_t                   state_next;
   logic [ADDR_W-1:0]        cnt_reg;
   logic [DATA_W-1:0]        out_data_reg;
   logic                     accept;
   logic                     last_beat;
   logic                     row_clear;
   logic                     pending;
   logic signed [ACC_W-1:0]  acc;

   assign accept    = PIX_VALID && (state_reg == RUN);
   assign last_beat = accept && (cnt_reg == ADDR_W'(N_ELEM - 1));
   assign row_clear = (state_reg == IDLE) && START;

   q88_mac_stage u_mac (
      .clk     (CLK),
      .srst    (RST),
      .clear   (row_clear),
      .beat    (accept),
      .act     (PIX_DATA),
      .w       (W_DO),
      .acc     (acc),
      .pending (pending)
   );

   // Next-state logic; START is only looked at in IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (START)      state_next = RUN;
         RUN:     if (last_beat)  state_next = DRAIN;
         DRAIN:   if (!pending)   state_next = DONE;
         DONE:    if (OUT_READY)  state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // State, element counter and result register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         out_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (row_clear) begin
            cnt_reg <= '0;
         end else if (accept) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if ((state_reg == DRAIN) && !pending) begin
            out_data_reg <= sat_q88(acc);
         end
      end
   end

   assign BUSY      = (state_reg != IDLE);
   assign PIX_READY = (state_reg == RUN);
   assign W_EN      = accept;
   assign W_ADDR    = cnt_reg;
   assign W_WE      = 1'b0;
   assign W_DI      = '0;
   assign OUT_VALID = (state_reg == DONE);
   assign OUT_DATA  = out_data_reg;

endmodule
